// File: rtl/spi_xfer_sequencer_if.sv
// Bundles the command, SPI-master PISO/SIPO and response signals of spi_xfer_sequencer.
// The slave modport is the sequencer's view; the master modport is the view of whatever drives it.
interface spi_xfer_sequencer_if #(
  parameter int MAX_XFER_SIZE  = 32,
  parameter int XFER_CNT_WIDTH = $clog2(MAX_XFER_SIZE),
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4
);
  logic [MAX_XFER_SIZE-1:0]         i_cmd_data;
  logic [XFER_CNT_WIDTH-1:0]        i_cmd_size;
  logic                             i_cmd_valid;
  logic                             o_cmd_ready;
  logic [MAX_XFER_SIZE-1:0]         o_piso_data;
  logic [XFER_CNT_WIDTH-1:0]        o_piso_xfer_size;
  logic                             o_piso_req;
  logic                             i_piso_ack;
  logic [MAX_XFER_SIZE-1:0]         i_sipo_data;
  logic                             i_sipo_rdy;
  logic [MAX_XFER_SIZE-1:0]         o_rsp_data;
  logic                             o_rsp_err;
  logic                             o_rsp_valid;
  logic                             i_rsp_ready;
  logic                             o_busy;
  logic [$clog2(CMD_DEPTH+1)-1:0]   o_cmd_count;
  logic [$clog2(RSP_DEPTH+1)-1:0]   o_rsp_count;

  modport slave (
    input  i_cmd_data, i_cmd_size, i_cmd_valid, i_piso_ack, i_sipo_data, i_sipo_rdy, i_rsp_ready,
    output o_cmd_ready, o_piso_data, o_piso_xfer_size, o_piso_req, o_rsp_data, o_rsp_err,
           o_rsp_valid, o_busy, o_cmd_count, o_rsp_count
  );

  modport master (
    output i_cmd_data, i_cmd_size, i_cmd_valid, i_piso_ack, i_sipo_data, i_sipo_rdy, i_rsp_ready,
    input  o_cmd_ready, o_piso_data, o_piso_xfer_size, o_piso_req, o_rsp_data, o_rsp_err,
           o_rsp_valid, o_busy, o_cmd_count, o_rsp_count
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Command FIFO -> one-at-a-time SPI master transfer -> response FIFO with per-transfer timeout.
//   state      | meaning
//   S_IDLE     | no transfer outstanding; pops a command when one is queued and response space exists
//   S_REQ      | o_piso_req high, waiting for the master to ack (or finish, or time out)
//   S_WAIT_RSP | acked, waiting for i_sipo_rdy or timeout
module spi_xfer_sequencer #(
  parameter int MAX_XFER_SIZE  = 32,
  parameter int XFER_CNT_WIDTH = $clog2(MAX_XFER_SIZE),
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_WIDTH       = 16
) (
  input logic i_sys_clk,
  input logic i_rst,
  spi_xfer_sequencer_if.slave bus
);
  localparam int CPW     = $clog2(CMD_DEPTH);
  localparam int RPW     = $clog2(RSP_DEPTH);
  localparam int CCW     = $clog2(CMD_DEPTH+1);
  localparam int RCW     = $clog2(RSP_DEPTH+1);
  localparam int TO_LOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CCW-1:0]      CMD_FULL = CCW'(CMD_DEPTH);
  localparam logic [RCW-1:0]      RSP_FULL = RCW'(RSP_DEPTH);
  localparam logic [TO_WIDTH-1:0] TO_INIT  = TO_WIDTH'(TO_LOAD);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP} state_t;
  state_t state;

  logic [MAX_XFER_SIZE-1:0]  cmd_data_mem [CMD_DEPTH];
  logic [XFER_CNT_WIDTH-1:0] cmd_size_mem [CMD_DEPTH];
  logic [CPW-1:0]            cmd_wr_ptr, cmd_rd_ptr;
  logic [CCW-1:0]            cmd_count;
  logic                      cmd_push, cmd_pop;

  logic [MAX_XFER_SIZE-1:0]  rsp_data_mem [RSP_DEPTH];
  logic                      rsp_err_mem  [RSP_DEPTH];
  logic [RPW-1:0]            rsp_wr_ptr, rsp_rd_ptr;
  logic [RCW-1:0]            rsp_count;
  logic                      rsp_push, rsp_pop, rsp_push_err, rsp_valid;
  logic [MAX_XFER_SIZE-1:0]  rsp_push_data;

  logic [MAX_XFER_SIZE-1:0]  piso_data;
  logic [XFER_CNT_WIDTH-1:0] piso_size;
  logic                      piso_req, busy, active, timeout_hit;
  logic [TO_WIDTH-1:0]       to_cnt;

  // Timeout is a down-counter loaded with TIMEOUT_CYCLES-1; terminal count is zero.
  assign active        = (state == S_REQ) || (state == S_WAIT_RSP);
  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (to_cnt == '0);
  assign cmd_push      = bus.i_cmd_valid && (cmd_count < CMD_FULL);
  assign cmd_pop       = (state == S_IDLE) && (cmd_count != '0) && (rsp_count < RSP_FULL);
  assign rsp_push      = active && (bus.i_sipo_rdy || timeout_hit);
  assign rsp_push_err  = !bus.i_sipo_rdy;
  assign rsp_push_data = bus.i_sipo_rdy ? bus.i_sipo_data : '0;
  assign rsp_valid     = (rsp_count != '0);
  assign rsp_pop       = rsp_valid && bus.i_rsp_ready;

  always_ff @(posedge i_sys_clk) begin
    if (cmd_push) begin
      cmd_data_mem[cmd_wr_ptr] <= bus.i_cmd_data;
      cmd_size_mem[cmd_wr_ptr] <= bus.i_cmd_size;
    end
    if (rsp_push) begin
      rsp_data_mem[rsp_wr_ptr] <= rsp_push_data;
      rsp_err_mem[rsp_wr_ptr]  <= rsp_push_err;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: ;
      endcase
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + 1'b1;
        2'b01:   rsp_count <= rsp_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      piso_req  <= 1'b0;
      piso_data <= '0;
      piso_size <= '0;
      busy      <= 1'b0;
      to_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_pop) begin
            piso_data <= cmd_data_mem[cmd_rd_ptr];
            piso_size <= cmd_size_mem[cmd_rd_ptr];
            to_cnt    <= TO_INIT;
            piso_req  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          // A finished transfer (or timeout) takes priority over a same-cycle ack.
          if (rsp_push) begin
            piso_req <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
            if (bus.i_piso_ack) begin
              piso_req <= 1'b0;
              state    <= S_WAIT_RSP;
            end
          end
        end
        S_WAIT_RSP: begin
          if (rsp_push) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        default: begin
          piso_req <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_cmd_ready      = (cmd_count < CMD_FULL);
  assign bus.o_cmd_count      = cmd_count;
  assign bus.o_rsp_count      = rsp_count;
  assign bus.o_rsp_valid      = rsp_valid;
  assign bus.o_rsp_data       = rsp_valid ? rsp_data_mem[rsp_rd_ptr] : '0;
  assign bus.o_rsp_err        = rsp_valid ? rsp_err_mem[rsp_rd_ptr] : 1'b0;
  assign bus.o_piso_req       = piso_req;
  assign bus.o_piso_data      = piso_data;
  assign bus.o_piso_xfer_size = piso_size;
  assign bus.o_busy           = busy;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed and randomized bench for spi_xfer_sequencer with a queue-based command/response model.
module tb_spi_xfer_sequencer;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam int CD = 4;
  localparam int RD = 4;
  localparam int TO = 48;

  typedef struct { logic [DW-1:0] data; logic [SW-1:0] size; } cmd_t;
  typedef struct { logic [DW-1:0] data; logic err; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_sequencer_if #(.MAX_XFER_SIZE(DW), .XFER_CNT_WIDTH(SW), .CMD_DEPTH(CD), .RSP_DEPTH(RD)) bus ();

  spi_xfer_sequencer #(
    .MAX_XFER_SIZE(DW), .XFER_CNT_WIDTH(SW), .CMD_DEPTH(CD), .RSP_DEPTH(RD),
    .TIMEOUT_CYCLES(TO), .TO_WIDTH(16)
  ) u_dut (
    .i_sys_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int checks = 0;
  int failures = 0;
  int busy_age = 0;

  // Number of whole cycles the current transfer has been outstanding.
  always @(posedge clk) busy_age <= bus.o_busy ? busy_age + 1 : 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [DW-1:0] d, input logic [SW-1:0] s);
    cmd_t c;
    int n = 0;
    while (!bus.o_cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready", bus.o_cmd_ready, 1);
    bus.i_cmd_data  = d;
    bus.i_cmd_size  = s;
    bus.i_cmd_valid = 1'b1;
    if (bus.o_cmd_ready) begin
      c.data = d;
      c.size = s;
      cmd_q.push_back(c);
    end
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.o_piso_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", bus.o_piso_req, 1);
  endtask

  // Acts as the SPI master for one transfer. rdy_at == 0: the master never completes it.
  task automatic serve(input int ack_at, input int rdy_at, input logic [DW-1:0] rd);
    cmd_t c;
    rsp_t r;
    int k;
    int guard = 0;
    bit acked = 0;
    bit done = 0;
    bit exp_err;
    wait_req();
    c.data = '0;
    c.size = '0;
    if (cmd_q.size() != 0) c = cmd_q.pop_front();
    chk("piso_data", bus.o_piso_data, c.data);
    chk("piso_size", 32'(bus.o_piso_xfer_size), 32'(c.size));
    exp_err = (rdy_at == 0) || (rdy_at > TO);
    while (!done && guard < TO + 10) begin
      k = busy_age + 1;
      bus.i_piso_ack  = !acked && (k >= ack_at);
      bus.i_sipo_rdy  = !exp_err && (k >= rdy_at) && (acked || bus.i_piso_ack);
      bus.i_sipo_data = bus.i_sipo_rdy ? rd : $urandom();
      if (bus.i_piso_ack) acked = 1;
      done = bus.i_sipo_rdy || (exp_err && k >= TO);
      tick();
      bus.i_piso_ack = 1'b0;
      bus.i_sipo_rdy = 1'b0;
      if (!done) begin
        chk("busy_mid", bus.o_busy, 1);
        chk("req_mid", bus.o_piso_req, !acked);
      end
      guard++;
    end
    chk("busy_end", bus.o_busy, 0);
    chk("req_end", bus.o_piso_req, 0);
    r.data = exp_err ? '0 : rd;
    r.err  = exp_err;
    rsp_q.push_back(r);
    chk("rsp_count_push", bus.o_rsp_count, rsp_q.size());
  endtask

  task automatic serve_rand();
    int a = $urandom_range(1, 4);
    int mode = $urandom_range(0, 5);
    if (mode == 0)      serve(a, 0, $urandom());
    else if (mode == 1) serve(a, TO, $urandom());
    else                serve(a, a + $urandom_range(0, 12), $urandom());
  endtask

  task automatic pop_rsp();
    rsp_t r;
    chk("rsp_valid", bus.o_rsp_valid, rsp_q.size() != 0);
    if (rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      chk("rsp_data", bus.o_rsp_data, r.data);
      chk("rsp_err", bus.o_rsp_err, r.err);
    end
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
    chk("rsp_count_pop", bus.o_rsp_count, rsp_q.size());
  endtask

  initial begin
    cmd_t c;
    int n;
    bus.i_cmd_data = '0; bus.i_cmd_size = '0; bus.i_cmd_valid = 1'b0;
    bus.i_piso_ack = 1'b0; bus.i_sipo_data = '0; bus.i_sipo_rdy = 1'b0; bus.i_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", bus.o_piso_req, 0);
    chk("rst_pdata", bus.o_piso_data, 0);
    chk("rst_psize", 32'(bus.o_piso_xfer_size), 0);
    chk("rst_rvalid", bus.o_rsp_valid, 0);
    chk("rst_rdata", bus.o_rsp_data, 0);
    chk("rst_rerr", bus.o_rsp_err, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_ccnt", bus.o_cmd_count, 0);
    chk("rst_rcnt", bus.o_rsp_count, 0);
    chk("rst_cready", bus.o_cmd_ready, 1);
    rst = 1'b0;
    tick();

    // Single command: latency from empty, ack at 3, sipo_rdy at 40.
    bus.i_cmd_data = 32'hA5A5_0F0F; bus.i_cmd_size = 5'd31; bus.i_cmd_valid = 1'b1;
    c.data = 32'hA5A5_0F0F; c.size = 5'd31;
    cmd_q.push_back(c);
    tick();
    bus.i_cmd_valid = 1'b0;
    chk("lat_ccnt1", bus.o_cmd_count, 1);
    chk("lat_req0", bus.o_piso_req, 0);
    tick();
    chk("lat_req1", bus.o_piso_req, 1);
    chk("lat_ccnt0", bus.o_cmd_count, 0);
    serve(3, 40, 32'h1234_5678);
    pop_rsp();

    // Fill: one in flight plus four queued; a push during the FSM's pop of a full FIFO is refused.
    for (int i = 0; i < 5; i++) push_cmd($urandom(), 5'($urandom_range(0, 31)));
    chk("fill_ccnt", bus.o_cmd_count, 4);
    chk("fill_cready", bus.o_cmd_ready, 0);
    serve(1, 2, $urandom());
    bus.i_cmd_data = 32'hDEAD_BEEF; bus.i_cmd_valid = 1'b1;
    chk("full_cready", bus.o_cmd_ready, 0);
    tick();
    bus.i_cmd_valid = 1'b0;
    chk("full_reject_ccnt", bus.o_cmd_count, 3);
    chk("b2b_req", bus.o_piso_req, 1);
    pop_rsp();
    repeat (4) begin
      serve($urandom_range(1, 3), $urandom_range(4, 10), $urandom());
      pop_rsp();
    end

    // Response backpressure: six commands, four responses, then the FSM parks.
    for (int i = 0; i < 5; i++) push_cmd($urandom(), 5'($urandom_range(0, 31)));
    serve(1, 3, $urandom());
    push_cmd($urandom(), 5'($urandom_range(0, 31)));
    repeat (3) serve(1, 3, $urandom());
    repeat (5) tick();
    chk("bp_busy", bus.o_busy, 0);
    chk("bp_req", bus.o_piso_req, 0);
    chk("bp_ccnt", bus.o_cmd_count, 2);
    chk("bp_rcnt", bus.o_rsp_count, 4);
    pop_rsp();
    serve(2, 5, $urandom());
    repeat (3) tick();
    chk("bp_park2_ccnt", bus.o_cmd_count, 1);
    chk("bp_park2_busy", bus.o_busy, 0);
    repeat (4) pop_rsp();
    serve(2, 5, $urandom());
    pop_rsp();
    chk("bp_empty", bus.o_rsp_valid, 0);

    // Timeout, same-cycle ack+rdy, rdy on the timeout cycle, spurious events in IDLE.
    push_cmd($urandom(), 5'd7);
    serve(2, 0, 32'h0);
    pop_rsp();
    push_cmd($urandom(), 5'd8);
    serve(3, 3, $urandom());
    pop_rsp();
    push_cmd($urandom(), 5'd9);
    serve(2, TO, $urandom());
    pop_rsp();
    bus.i_sipo_rdy = 1'b1; bus.i_piso_ack = 1'b1; bus.i_sipo_data = $urandom();
    tick();
    bus.i_sipo_rdy = 1'b0; bus.i_piso_ack = 1'b0;
    tick();
    chk("spur_rcnt", bus.o_rsp_count, 0);
    chk("spur_busy", bus.o_busy, 0);
    chk("spur_rvalid", bus.o_rsp_valid, 0);

    // Randomized traffic against the queue model.
    repeat (25) begin
      n = $urandom_range(1, 3);
      repeat (n) if (cmd_q.size() < CD) push_cmd($urandom(), 5'($urandom_range(0, 31)));
      if (rsp_q.size() == RD) pop_rsp();
      if (cmd_q.size() != 0) serve_rand();
      n = $urandom_range(0, rsp_q.size());
      repeat (n) pop_rsp();
    end
    while (cmd_q.size() != 0) begin
      if (rsp_q.size() == RD) pop_rsp();
      serve_rand();
    end
    while (rsp_q.size() != 0) pop_rsp();

    // Reset while in WAIT_RSP with two commands queued and a response pending.
    push_cmd($urandom(), 5'd3);
    serve(1, 2, $urandom());
    for (int i = 0; i < 3; i++) push_cmd($urandom(), 5'd4);
    wait_req();
    bus.i_piso_ack = 1'b1;
    tick();
    bus.i_piso_ack = 1'b0;
    chk("wr_busy", bus.o_busy, 1);
    chk("wr_ccnt", bus.o_cmd_count, 2);
    chk("wr_rvalid", bus.o_rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", bus.o_piso_req, 0);
    chk("arst_busy", bus.o_busy, 0);
    chk("arst_ccnt", bus.o_cmd_count, 0);
    chk("arst_rcnt", bus.o_rsp_count, 0);
    chk("arst_rvalid", bus.o_rsp_valid, 0);
    tick();
    rst = 1'b0;
    cmd_q.delete();
    rsp_q.delete();
    repeat (3) tick();
    chk("post_rst_req", bus.o_piso_req, 0);
    push_cmd(32'hCAFE_F00D, 5'd15);
    serve(2, 6, 32'h0BAD_CAFE);
    pop_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
